sine_frequency_estimator: RTL and testbench

//  Receive-side counterpart of the DDS phase-to-amplitude path: takes the sampled sine amplitude stream
//  (offset 100, amplitude 100, 10-bit) and recovers its period and the frequency control word.

---
 rtl/dds_pkg.sv | 15 +
 rtl/sine_frequency_estimator_if.sv | 10 +
 rtl/dds_seq_divider.sv | 64 ++++++
 rtl/sine_frequency_estimator.sv | 166 ++++++++++++++++
 tb/tb_sine_frequency_estimator.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared DDS constants and sine-tracking FSM states
package dds_pkg;

  typedef enum logic [1:0] {
    SEEK_LOW = 2'd0,
    ARMED    = 2'd1,
    HIGH     = 2'd2
  } dds_state_t;

  // The sine is offset by its own amplitude so samples never go negative.
  localparam int DDS_AMPLITUDE = 100;
  localparam int DDS_MIDSCALE  = DDS_AMPLITUDE;
  localparam int DDS_PHASE_W   = 10;

endpackage

// File: rtl/sine_frequency_estimator_if.sv
// rtl/sine_frequency_estimator_if.sv - amplitude sample stream into the estimator
interface sine_frequency_estimator_if #(
  parameter int DATA_W = 10
);
  logic              sample_valid;
  logic [DATA_W-1:0] data_sin;

  modport master (output sample_valid, output data_sin);
  modport slave  (input  sample_valid, input  data_sin);
endinterface

// File: rtl/dds_seq_divider.sv
// rtl/dds_seq_divider.sv - restoring divider, one quotient bit per clock
module dds_seq_divider #(
  parameter int DIVIDEND_W = 13,
  parameter int DIVISOR_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int ITER_W = $clog2(DIVIDEND_W);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIVIDEND_W - 1);

  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  rem;
  logic [ITER_W-1:0]     iter;
  logic [DIVISOR_W:0]    rem_sh;
  logic [DIVISOR_W:0]    rem_sub;
  logic                  fits;

  // Dividend bits shift out of the top of dvd while quotient bits shift in at the bottom.
  always_comb begin
    rem_sh  = {rem, dvd[DIVIDEND_W-1]};
    fits    = (rem_sh >= {1'b0, dvs});
    rem_sub = fits ? (rem_sh - {1'b0, dvs}) : rem_sh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvs  <= '0;
      dvd  <= '0;
      rem  <= '0;
      iter <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        dvs  <= divisor;
        dvd  <= dividend;
        rem  <= '0;
        iter <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem  <= rem_sub[DIVISOR_W-1:0];
        dvd  <= {dvd[DIVIDEND_W-2:0], fits};
        iter <= iter + ITER_W'(1);
        if (iter == ITER_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = dvd;

endmodule

// File: rtl/sine_frequency_estimator.sv
// rtl/sine_frequency_estimator.sv - recovers period, average period and FCW from a sampled sine
// FCW_EST_EN enables the serial divider that produces fcw/fcw_valid.
module sine_frequency_estimator
  import dds_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int MID      = DDS_MIDSCALE,
  parameter int HYST     = 4,
  parameter int CNT_W    = 12,
  parameter int AVG_LOG2 = 2,
  parameter int PHASE_W  = DDS_PHASE_W
) (
  input  logic               clk,
  input  logic               reset_n,
  sine_frequency_estimator_if.slave smp,
  output logic [CNT_W-1:0]   period,
  output logic               period_valid,
  output logic [CNT_W-1:0]   avg_period,
  output logic               avg_valid,
  output logic [PHASE_W-1:0] fcw,
  output logic               fcw_valid,
  output logic               locked,
  output logic               timeout
);

  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam logic [DATA_W-1:0]   HI_TH    = DATA_W'(MID);
  localparam logic [DATA_W-1:0]   LO_TH    = DATA_W'(MID - HYST);
  localparam logic [CNT_W-1:0]    CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [AVG_LOG2-1:0] IDX_LAST = '1;

  dds_state_t state, state_next;
  logic                crossing;
  logic                cnt_sat;
  logic                started;
  logic [CNT_W-1:0]    cnt;
  logic [AVG_LOG2-1:0] idx;
  logic [SUM_W-1:0]    acc;
  logic [CNT_W-1:0]    period_new;
  logic [SUM_W-1:0]    sum_new;

  assign period_new = cnt + CNT_W'(1);
  assign sum_new    = acc + SUM_W'(period_new);

  always_comb begin
    state_next = state;
    crossing   = 1'b0;
    cnt_sat    = 1'b0;
    if (smp.sample_valid) begin
      case (state)
        SEEK_LOW: if (smp.data_sin <= LO_TH) state_next = ARMED;
        ARMED: begin
          if (smp.data_sin >= HI_TH) begin
            state_next = HIGH;
            crossing   = 1'b1;
          end
        end
        HIGH:     if (smp.data_sin <= LO_TH) state_next = ARMED;
        default:  state_next = SEEK_LOW;
      endcase
      // A crossing on the saturating sample takes priority over the timeout.
      if (!crossing && started && (cnt == CNT_LAST)) begin
        cnt_sat    = 1'b1;
        state_next = SEEK_LOW;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SEEK_LOW;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started      <= 1'b0;
      cnt          <= '0;
      idx          <= '0;
      acc          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      avg_period   <= '0;
      avg_valid    <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      avg_valid    <= 1'b0;
      timeout      <= 1'b0;
      if (smp.sample_valid) begin
        if (crossing) begin
          cnt <= '0;
          if (!started) begin
            started <= 1'b1;
          end else begin
            period       <= period_new;
            period_valid <= 1'b1;
            if (idx == IDX_LAST) begin
              avg_period <= sum_new[SUM_W-1:AVG_LOG2];
              avg_valid  <= 1'b1;
              locked     <= 1'b1;
              acc        <= '0;
              idx        <= '0;
            end else begin
              acc <= sum_new;
              idx <= idx + AVG_LOG2'(1);
            end
          end
        end else if (cnt_sat) begin
          cnt     <= '0;
          started <= 1'b0;
          timeout <= 1'b1;
          locked  <= 1'b0;
          acc     <= '0;
          idx     <= '0;
        end else if (started) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef FCW_EST_EN
  localparam int DIVIDEND_W = PHASE_W + AVG_LOG2 + 1;
  localparam logic [DIVIDEND_W-1:0] DIVIDEND = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [DIVIDEND_W-1:0] div_q;

  // Start on the same edge that registers avg_valid so fcw lands a fixed 14 cycles later.
  assign div_start = smp.sample_valid && crossing && started && (idx == IDX_LAST) && !div_busy;

  dds_seq_divider #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (SUM_W)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (sum_new),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcw       <= '0;
      fcw_valid <= 1'b0;
    end else begin
      fcw_valid <= div_done;
      if (div_done) begin
        if (|div_q[DIVIDEND_W-1:PHASE_W]) fcw <= '1;
        else                              fcw <= div_q[PHASE_W-1:0];
      end
    end
  end
`else
  assign fcw       = '0;
  assign fcw_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sine_frequency_estimator.sv
// tb/tb_sine_frequency_estimator.sv - directed scoreboard bench for sine_frequency_estimator
module tb_sine_frequency_estimator;
  import dds_pkg::*;

  localparam int CNT_W   = 12;
  localparam int PHASE_W = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sine_frequency_estimator_if #(.DATA_W(10)) sif ();

  logic [CNT_W-1:0]   period, avg_period;
  logic               period_valid, avg_valid, fcw_valid, locked, timeout;
  logic [PHASE_W-1:0] fcw;

  sine_frequency_estimator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .smp          (sif),
    .period       (period),
    .period_valid (period_valid),
    .avg_period   (avg_period),
    .avg_valid    (avg_valid),
    .fcw          (fcw),
    .fcw_valid    (fcw_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  typedef struct { int lo; int hi; } rng_t;
  rng_t q_per[$];
  int   q_avg[$];
  int   q_fcw[$];
  rng_t mon_e;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, last_avg_cyc = 0;
  int n_period = 0, n_timeout = 0, n_fcw_seen = 0;
  int phase = 0;
  int p0, t0;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic push_exp(input int plo, input int phi, input int nper,
                          input int avg, input int navg, input int f, input bit with_fcw);
    rng_t e;
    e.lo = plo;
    e.hi = phi;
    for (int i = 0; i < nper; i++) q_per.push_back(e);
    for (int i = 0; i < navg; i++) q_avg.push_back(avg);
`ifdef FCW_EST_EN
    if (with_fcw) for (int i = 0; i < navg; i++) q_fcw.push_back(f);
`else
    if (with_fcw && f < 0) q_fcw.push_back(f);
`endif
  endtask

  task automatic check_queues(input string t);
    check({t, "_period_q_left"}, q_per.size(), 0);
    check({t, "_avg_q_left"}, q_avg.size(), 0);
    check({t, "_fcw_q_left"}, q_fcw.size(), 0);
  endtask

  function automatic int dds_amp(input int ph);
    real r;
    r = 100.0 + 100.0 * $sin(2.0 * 3.14159265358979 * real'(ph) / 1024.0);
    return $rtoi(r + 0.5);
  endfunction

  // Ideal DDS samples; optional +/-3 noise only near mid-scale, never pulling the phase-0 sample below 100.
  task automatic drive_sine(input int f, input int nsamp, input bit noise, input bit half_duty);
    int a;
    for (int i = 0; i < nsamp; i++) begin
      if (half_duty) begin
        @(negedge clk);
        sif.sample_valid = 1'b0;
      end
      @(negedge clk);
      a = dds_amp(phase);
      if (noise && a >= 90 && a <= 110)
        a = a + ((phase == 0) ? int'($urandom_range(0, 3)) : (int'($urandom_range(0, 6)) - 3));
      sif.sample_valid = 1'b1;
      sif.data_sin     = 10'(a);
      phase = (phase + f) % 1024;
    end
    @(negedge clk);
    sif.sample_valid = 1'b0;
  endtask

  task automatic drive_const(input int v, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      @(negedge clk);
      sif.sample_valid = 1'b1;
      sif.data_sin     = 10'(v);
    end
    @(negedge clk);
    sif.sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sif.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string t);
    check({t, "_period"}, period, 0);
    check({t, "_period_valid"}, period_valid, 0);
    check({t, "_avg_period"}, avg_period, 0);
    check({t, "_avg_valid"}, avg_valid, 0);
    check({t, "_fcw"}, fcw, 0);
    check({t, "_fcw_valid"}, fcw_valid, 0);
    check({t, "_locked"}, locked, 0);
    check({t, "_timeout"}, timeout, 0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (period_valid) begin
      n_period++;
      check("period_expected", int'(q_per.size() > 0), 1);
      if (q_per.size() > 0) begin
        mon_e = q_per.pop_front();
        check_rng("period", period, mon_e.lo, mon_e.hi);
      end
    end
    if (avg_valid) begin
      last_avg_cyc = cyc;
      check("avg_expected", int'(q_avg.size() > 0), 1);
      if (q_avg.size() > 0) check("avg_period", avg_period, q_avg.pop_front());
      check("locked_at_avg", locked, 1);
    end
    if (timeout) n_timeout++;
    if (fcw_valid) begin
      n_fcw_seen++;
`ifdef FCW_EST_EN
      check("fcw_expected", int'(q_fcw.size() > 0), 1);
      if (q_fcw.size() > 0) check("fcw", fcw, q_fcw.pop_front());
      check("fcw_latency", cyc - last_avg_cyc, 14);
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sif.sample_valid = 1'b0;
    sif.data_sin     = '0;
    reset_n          = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", int'(dut.state), int'(SEEK_LOW));
    reset_n = 1'b1;

    // Clean FCW=16 sine: crossings every 64 samples, two full averages.
    phase = 768;
    push_exp(64, 64, 8, 64, 2, 16, 1'b1);
    drive_sine(16, 529, 1'b0, 1'b0);
    idle(20);
    check_queues("t1");
    check("t1_locked", locked, 1);

    // FCW=5: periods alternate 204/205, average truncates to 204.
    do_reset();
    phase = 768;
    push_exp(204, 205, 5, 204, 1, 5, 1'b1);
    drive_sine(5, 1100, 1'b0, 1'b0);
    idle(20);
    check_queues("t2");
    check("t2_locked", locked, 1);

    // Lock, then hold mid-scale until the period counter saturates.
    do_reset();
    phase = 768;
    push_exp(64, 64, 4, 64, 1, 16, 1'b1);
    drive_sine(16, 273, 1'b0, 1'b0);
    idle(20);
    check("t3_locked_before", locked, 1);
    t0 = n_timeout;
    drive_const(100, 4094);
    idle(3);
    check("t3_no_early_timeout", n_timeout - t0, 0);
    drive_const(100, 1);
    idle(3);
    check("t3_timeout_count", n_timeout - t0, 1);
    check("t3_locked_after", locked, 0);
    check("t3_state", int'(dut.state), int'(SEEK_LOW));
    check_queues("t3");

    // Noise near mid-scale must not add crossings.
    do_reset();
    phase = 768;
    p0 = n_period;
    push_exp(64, 64, 4, 64, 1, 16, 1'b1);
    drive_sine(16, 273, 1'b1, 1'b0);
    idle(20);
    check("t4_period_count", n_period - p0, 4);
    check_queues("t4");

    // Half-rate sample_valid: period counts samples, not clocks.
    do_reset();
    phase = 768;
    push_exp(64, 64, 4, 64, 1, 16, 1'b1);
    drive_sine(16, 273, 1'b0, 1'b1);
    idle(20);
    check_queues("t5");

    // Reset in the middle of a division, then re-acquire from scratch.
    do_reset();
    phase = 768;
    push_exp(64, 64, 4, 64, 1, 0, 1'b0);
    drive_sine(16, 273, 1'b0, 1'b0);
    idle(4);
    check("t6_avg_before_reset", avg_period, 64);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    p0 = n_period;
    phase = 768;
    drive_sine(16, 80, 1'b0, 1'b0);
    idle(3);
    check("t6_no_early_period", n_period - p0, 0);
    push_exp(64, 64, 1, 0, 0, 0, 1'b0);
    drive_sine(16, 1, 1'b0, 1'b0);
    idle(20);
    check("t6_first_period", n_period - p0, 1);
    check_queues("t6");

`ifndef FCW_EST_EN
    check("fcw_valid_never", n_fcw_seen, 0);
    check("fcw_tied_zero", fcw, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
